program_fetch_sequencer: RTL and testbench
==========================================

# program_fetch_sequencer

Instruction fetch sequencer for the K2 processor. It drives the 4-bit step address into a combinational program ROM and registers the returned 8-bit instruction into an instruction register. It presents that instruction to the core through a valid/ready handshake. It also handles sequential advance, jump redirection, end-of-program detection, abort, and a retired-instruction counter.

## Interface
- PROG_LEN, 10: number of valid program addresses (0..PROG_LEN-1); 1..16.
- CNT_W, 8: width of the retired-instruction counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin (or restart) execution at address 0; honoured in IDLE and DONE only.
- abort  in  1  synchronous abort; returns to IDLE; highest priority after rst.
- s  out  4  ROM address; combinational.
- inst  in  8  ROM data for address s; combinational, same cycle.
- ir  out  8  registered instruction.
- ir_valid  out  1  ir holds an instruction not yet accepted.
- ir_ready  in  1  core accepts ir this cycle.
- jump  in  1  redirect; sampled only on an accepting cycle (ir_valid && ir_ready).
- jump_addr  in  4  redirect target.
- pc  out  4  address ir was fetched from.
- done  out  1  end of program reached.
- count  out  CNT_W  instructions accepted since last start; saturates at all-ones.

## Operation
- States: IDLE, HOLD, DONE.
- Reset values:
  - state = IDLE
  - ir = 8'h00
  - pc = 0
  - ir_valid = 0
  - done = 0
  - count = 0
- next = jump ? jump_addr : pc+1. The 4-bit add wraps; the wrap is irrelevant because of the end rule below.
- end condition (on an accepting cycle):
  - no jump: pc == PROG_LEN-1.
  - jump: jump_addr >= PROG_LEN.
- s by state:
  - IDLE and DONE: s = 0.
  - HOLD with ir_ready=1: s = next.
  - HOLD with ir_ready=0: s = pc.
- IDLE:
  - ir_valid = 0, done = 0.
  - On start: ir <= inst (address 0), pc <= 0, ir_valid <= 1, count <= 0, go to HOLD.
- HOLD:
  - ir_valid = 1.
  - ir_ready=0: ir, pc and count hold; jump and jump_addr are ignored.
  - ir_ready=1: count <= sat(count+1).
    - end: ir_valid <= 0, done <= 1, go to DONE. ir and pc keep the last accepted instruction.
    - otherwise: ir <= inst (address next), pc <= next, stay in HOLD.
- DONE:
  - done = 1, ir_valid = 0, count holds.
  - On start: behaves exactly as start in IDLE and clears done.
- abort:
  - Any state: go to IDLE next edge with ir_valid <= 0 and done <= 0.
  - count, ir and pc hold.
  - abort and start in the same cycle: abort wins.
- start is ignored in HOLD.
- jump_addr == pc on an accepting cycle is legal: the same instruction is reloaded and presented again.

## Timing
- start sampled at edge k: ir_valid = 1 and ir = ROM[0] after edge k. First-instruction latency is 1 cycle.
- Throughput is one instruction per cycle while ir_ready stays high. The next instruction is visible the cycle after acceptance.
- The jump redirect takes effect on the accepting edge; no bubble.
- done rises on the edge that accepts the last instruction, in the same edge that ir_valid falls.
- rst asserted mid-program: all outputs take reset values immediately, without waiting for a clock edge.
- There is a combinational path jump/jump_addr/ir_ready -> s. The ROM must be combinational.

## Test plan
Bench ROM contents, addresses 0..9: 08, f8, 09, f9, 0a, fa, d9, c9, 04, f0. PROG_LEN = 10.

- **Reset:** assert rst mid-HOLD with no clock edge -> ir=00, pc=0, ir_valid=0, done=0, count=0 immediately. After release, state is IDLE and s=0.
- **Straight run:** start for 1 cycle, then ir_ready held at 1 -> ir sequence 08,f8,09,f9,0a,fa,d9,c9,04,f0 on 10 consecutive cycles with pc 0..9. Then done=1, ir_valid=0, count=10.
- **Back-pressure:** ir_ready low for 3 cycles while ir=09 at pc=2, with jump=1 and jump_addr=7 driven during the stall -> ir, pc and count hold and the jump is ignored. The first ready cycle advances to pc=3, ir=f9.
- **Jump:** accept at pc=1 with jump=1, jump_addr=6 -> next ir=d9, pc=6. Accept at pc=3 with jump_addr=12 -> DONE, count incremented.
- **Abort/restart:** abort at pc=5, start at the same cycle, count=6 -> IDLE, ir_valid=0, count stays 6. A later start gives ir=08, pc=0, count=0. start in DONE restarts identically.
- **Saturation:** CNT_W=3, loop by jumping from pc=9 to address 0 -> count reaches 7 and stays at 7.

Source files
------------

// File: rtl/program_fetch_sequencer.sv
// Instruction fetch sequencer: addresses a combinational program ROM, registers the
// returned instruction and presents it to the core through a valid/ready handshake.
module program_fetch_sequencer #(
  parameter int PROG_LEN = 10,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [3:0]       s,
  input  logic [7:0]       inst,
  output logic [7:0]       ir,
  output logic             ir_valid,
  input  logic             ir_ready,
  input  logic             jump,
  input  logic [3:0]       jump_addr,
  output logic [3:0]       pc,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [4:0] LEN  = 5'(PROG_LEN);
  localparam logic [3:0] LAST = 4'(PROG_LEN - 1);

  state_t     state, state_nx;
  logic [3:0] next_addr;
  logic       accept;
  logic       at_end;
  logic       load;
  logic       cnt_clr;
  logic       cnt_inc;

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    s         = 4'd0;
    ir_valid  = (state == HOLD);
    done      = (state == DONE);
    next_addr = jump ? jump_addr : pc + 4'd1;
    accept    = (state == HOLD) && ir_ready;
    at_end    = jump ? ({1'b0, jump_addr} >= LEN) : (pc == LAST);

    case (state)
      IDLE, DONE: begin
        // s is 0 here, so inst already carries the first instruction
        if (start) begin
          state_nx = HOLD;
          load     = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      HOLD: begin
        s = ir_ready ? next_addr : pc;
        if (accept) begin
          cnt_inc = 1'b1;
          if (at_end) state_nx = DONE;
          else        load     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (abort) begin
      state_nx = IDLE;
      load     = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ir    <= '0;
      pc    <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        ir <= inst;
        pc <= s;
      end
      if (cnt_clr)                     count <= '0;
      else if (cnt_inc && count != '1) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_program_fetch_sequencer.sv
// Randomized and directed bench for program_fetch_sequencer; two instances (8-bit
// and 3-bit counters) share stimulus and are compared against a behavioural model.
module tb_program_fetch_sequencer;

  localparam int PROG_LEN = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ir_ready = 1'b0;
  logic       jump = 1'b0;
  logic [3:0] jump_addr = 4'd0;

  logic [3:0] s_a, s_b, pc_a, pc_b;
  logic [7:0] inst_a, inst_b, ir_a, ir_b;
  logic       valid_a, valid_b, done_a, done_b;
  logic [7:0] count_a;
  logic [2:0] count_b;

  int passes = 0;
  int checks = 0;

  // behavioural model state
  logic       m_valid, m_done;
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  int         m_cnt;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_rd(input logic [3:0] a);
    case (a)
      4'd0: return 8'h08;
      4'd1: return 8'hf8;
      4'd2: return 8'h09;
      4'd3: return 8'hf9;
      4'd4: return 8'h0a;
      4'd5: return 8'hfa;
      4'd6: return 8'hd9;
      4'd7: return 8'hc9;
      4'd8: return 8'h04;
      4'd9: return 8'hf0;
      default: return 8'hee;
    endcase
  endfunction

  assign inst_a = rom_rd(s_a);
  assign inst_b = rom_rd(s_b);

  program_fetch_sequencer #(.PROG_LEN(PROG_LEN), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s(s_a), .inst(inst_a),
    .ir(ir_a), .ir_valid(valid_a), .ir_ready(ir_ready), .jump(jump),
    .jump_addr(jump_addr), .pc(pc_a), .done(done_a), .count(count_a)
  );

  program_fetch_sequencer #(.PROG_LEN(PROG_LEN), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s(s_b), .inst(inst_b),
    .ir(ir_b), .ir_valid(valid_b), .ir_ready(ir_ready), .jump(jump),
    .jump_addr(jump_addr), .pc(pc_b), .done(done_b), .count(count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_pc    = 4'd0;
    m_ir    = 8'h00;
    m_cnt   = 0;
  endtask

  task automatic check_outputs();
    check("ir_a",    {24'd0, ir_a},    {24'd0, m_ir});
    check("ir_b",    {24'd0, ir_b},    {24'd0, m_ir});
    check("pc_a",    {28'd0, pc_a},    {28'd0, m_pc});
    check("pc_b",    {28'd0, pc_b},    {28'd0, m_pc});
    check("valid_a", {31'd0, valid_a}, {31'd0, m_valid});
    check("valid_b", {31'd0, valid_b}, {31'd0, m_valid});
    check("done_a",  {31'd0, done_a},  {31'd0, m_done});
    check("done_b",  {31'd0, done_b},  {31'd0, m_done});
    check("count8",  {24'd0, count_a}, (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
    check("count3",  {29'd0, count_b}, (m_cnt > 7)   ? 32'd7   : 32'(m_cnt));
  endtask

  // One clock cycle: drive inputs, check the combinational ROM address, clock,
  // advance the model by the handshake rules and check the registered outputs.
  task automatic cycle(input logic st, input logic ab, input logic rdy,
                       input logic jp, input logic [3:0] ja);
    logic [3:0] nxt;
    logic [3:0] exp_s;
    start = st; abort = ab; ir_ready = rdy; jump = jp; jump_addr = ja;
    #1;
    nxt   = jp ? ja : 4'((int'(m_pc) + 1) % 16);
    exp_s = !m_valid ? 4'd0 : (rdy ? nxt : m_pc);
    check("s_a", {28'd0, s_a}, {28'd0, exp_s});
    check("s_b", {28'd0, s_b}, {28'd0, exp_s});
    @(posedge clk);
    if (ab) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
    end else if (!m_valid && st) begin
      m_valid = 1'b1;
      m_done  = 1'b0;
      m_pc    = 4'd0;
      m_ir    = rom_rd(4'd0);
      m_cnt   = 0;
    end else if (m_valid && rdy) begin
      m_cnt++;
      if (jp ? (int'(ja) >= PROG_LEN) : (int'(m_pc) == PROG_LEN - 1)) begin
        m_valid = 1'b0;
        m_done  = 1'b1;
      end else begin
        m_pc = nxt;
        m_ir = rom_rd(nxt);
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();

    // reset values, then release
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    cycle(0, 0, 0, 0, 4'd0);

    // straight run through the whole program
    cycle(1, 0, 0, 0, 4'd0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0);

    // restart from DONE, then back-pressure at pc=2 with a jump driven during the stall
    cycle(1, 0, 0, 0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 4'd7);
    cycle(0, 0, 1, 0, 4'd0);

    // start in HOLD is ignored; abort, then jumps: 1 -> 6 -> 3 -> out of range
    cycle(1, 0, 0, 0, 4'd0);
    cycle(0, 1, 0, 0, 4'd0);
    cycle(1, 0, 0, 0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0);
    cycle(0, 0, 1, 1, 4'd6);
    cycle(0, 0, 1, 1, 4'd3);
    cycle(0, 0, 1, 1, 4'd12);
    cycle(0, 0, 0, 0, 4'd0);

    // abort at pc=5 together with start, later restart; self-jump reloads
    cycle(1, 0, 0, 0, 4'd0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 4'd0);
    cycle(0, 0, 1, 1, 4'd5);
    cycle(1, 1, 1, 0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0);
    cycle(1, 0, 0, 0, 4'd0);
    cycle(0, 0, 1, 1, 4'd0);
    cycle(0, 0, 1, 1, 4'd10);

    // saturation: loop 9 -> 0 three times
    cycle(1, 0, 0, 0, 4'd0);
    for (int lap = 0; lap < 3; lap++) begin
      for (int p = 0; p < 9; p++) cycle(0, 0, 1, 0, 4'd0);
      cycle(0, 0, 1, 1, 4'd0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) == 0, ($urandom % 24) == 0, ($urandom % 4) != 0,
            ($urandom % 4) == 0, 4'($urandom % 16));
    end

    // asynchronous reset mid-HOLD, observed before any clock edge
    cycle(1, 0, 0, 0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0);
    cycle(0, 0, 1, 0, 4'd0);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst = 1'b0;
    cycle(0, 0, 1, 0, 4'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
